// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared types, reset constants and width helpers for the
// stream_mux block (N:1 valid/ready multiplexer with packet locking).
package stream_mux_pkg;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mode_e;

  localparam logic RST_OUT_VALID = 1'b0;
  localparam logic RST_OUT_LAST  = 1'b0;
  localparam logic RST_LOCK      = 1'b0;

  // Width of a channel index / select value for nCh channels
  function automatic int selWidth(input int nCh);
    return (nCh > 1) ? $clog2(nCh) : 1;
  endfunction

  // Round-robin pointer after reset: last channel, so channel 0 wins first
  function automatic int rstLastGrant(input int nCh);
    return nCh - 1;
  endfunction

endpackage

// File: rtl/stream_mux_if.sv
// stream_mux_if: producer-side and consumer-side stream signals of the
// stream_mux. The slave modport is the mux itself; master is its environment.
interface stream_mux_if
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8
);
  localparam int SEL_W = selWidth(N_CH);

  logic [N_CH-1:0]       in_valid;
  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_last;
  logic [N_CH-1:0]       in_ready;
  logic [SEL_W-1:0]      sel;
  logic                  rr_mode;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic                  out_last;
  logic [SEL_W-1:0]      out_chan;
  logic                  out_ready;

  modport slave (
    input  in_valid, in_data, in_last, sel, rr_mode, out_ready,
    output in_ready, out_valid, out_data, out_last, out_chan
  );

  modport master (
    output in_valid, in_data, in_last, sel, rr_mode, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_chan
  );

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter. Grants the first requesting
// channel found after the pointer, wrapping modulo N_CH. One-hot or zero.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N_CH = 4
)
(
  input  logic [N_CH-1:0]           req_i,
  input  logic [selWidth(N_CH)-1:0] ptr_i,
  input  logic                      en_i,
  output logic [N_CH-1:0]           gnt_o
);
  localparam int SEL_W = selWidth(N_CH);
  typedef logic [SEL_W:0] wide_t;

  // Scan channels ptr+1 .. ptr+N_CH (mod N_CH) and grant the first requester
  always_comb begin
    wide_t idx;
    logic  found;
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = wide_t'(ptr_i) + wide_t'(k);
      if (idx >= wide_t'(N_CH)) idx = idx - wide_t'(N_CH);
      if (en_i && !found && req_i[idx[SEL_W-1:0]]) begin
        gnt_o[idx[SEL_W-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux.sv
// stream_mux: N:1 streaming multiplexer with valid/ready handshake, packet
// locking and a single registered output stage. Round-robin arbitration is
// compiled in only when STREAM_MUX_RR_EN is defined; otherwise select mode only.
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8
)
(
  input logic         clk,
  input logic         rst,
  stream_mux_if.slave bus
);
  localparam int SEL_W = selWidth(N_CH);
  typedef logic [SEL_W-1:0] chan_t;

  logic             outValid_q, outValid_d;
  logic [WIDTH-1:0] outData_q, outData_d;
  logic             outLast_q, outLast_d;
  chan_t            outChan_q, outChan_d;
  logic             lock_q, lock_d;
  chan_t            lockCh_q, lockCh_d;

  logic [N_CH-1:0]  grant;
  logic [N_CH-1:0]  rrGnt;
  chan_t            grantIdx;
  logic             grantAny;
  logic             loadEn;
  logic             accept;
  logic [WIDTH-1:0] selData;
  logic             selLast;
  mode_e            modeEff;

`ifdef STREAM_MUX_RR_EN
  chan_t lastGrant_q, lastGrant_d;
  logic  rrEn;

  assign modeEff = mode_e'(bus.rr_mode);
  assign rrEn    = !lock_q && (modeEff == MODE_RR);

  rr_arbiter #(.N_CH(N_CH)) uArb (
    .req_i (bus.in_valid),
    .ptr_i (lastGrant_q),
    .en_i  (rrEn),
    .gnt_o (rrGnt)
  );

  // Pointer moves to the channel whose packet just completed
  always_comb begin
    lastGrant_d = lastGrant_q;
    if (accept && selLast) lastGrant_d = grantIdx;
  end

  // Round-robin pointer register
  always_ff @(posedge clk) begin
    if (rst) lastGrant_q <= chan_t'(rstLastGrant(N_CH));
    else     lastGrant_q <= lastGrant_d;
  end
`else
  logic unusedRrMode;

  assign modeEff      = MODE_SEL;
  assign rrGnt        = '0;
  assign unusedRrMode = bus.rr_mode;
`endif

  assign loadEn       = !outValid_q || bus.out_ready;
  assign grantAny     = |grant;
  assign accept       = grantAny && loadEn && !rst;
  assign bus.in_ready = rst ? '0 : (grant & {N_CH{loadEn}});

  // Grant: locked channel first, otherwise round-robin or explicit select
  always_comb begin
    grant = '0;
    if (lock_q) begin
      if (bus.in_valid[lockCh_q]) grant[lockCh_q] = 1'b1;
    end else if (modeEff == MODE_RR) begin
      grant = rrGnt;
    end else if (int'(bus.sel) < N_CH) begin
      if (bus.in_valid[bus.sel]) grant[bus.sel] = 1'b1;
    end
  end

  // Encode the grant and pick the granted channel's data slice and last flag
  always_comb begin
    grantIdx = '0;
    selData  = '0;
    selLast  = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) begin
        grantIdx = chan_t'(i);
        selData  = bus.in_data[i*WIDTH +: WIDTH];
        selLast  = bus.in_last[i];
      end
    end
  end

  // Output stage reload and packet lock bookkeeping on accepted beats
  always_comb begin
    outValid_d = outValid_q;
    outData_d  = outData_q;
    outLast_d  = outLast_q;
    outChan_d  = outChan_q;
    lock_d     = lock_q;
    lockCh_d   = lockCh_q;
    if (loadEn) begin
      outValid_d = accept;
      if (accept) begin
        outData_d = selData;
        outLast_d = selLast;
        outChan_d = grantIdx;
      end
    end
    if (accept) begin
      lock_d = !selLast;
      if (!selLast) lockCh_d = grantIdx;
    end
  end

  // Output register and lock state
  always_ff @(posedge clk) begin
    if (rst) begin
      outValid_q <= RST_OUT_VALID;
      outData_q  <= '0;
      outLast_q  <= RST_OUT_LAST;
      outChan_q  <= '0;
      lock_q     <= RST_LOCK;
      lockCh_q   <= '0;
    end else begin
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      outLast_q  <= outLast_d;
      outChan_q  <= outChan_d;
      lock_q     <= lock_d;
      lockCh_q   <= lockCh_d;
    end
  end

  assign bus.out_valid = outValid_q;
  assign bus.out_data  = outData_q;
  assign bus.out_last  = outLast_q;
  assign bus.out_chan  = outChan_q;

endmodule
